alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle RV32 ALU: executes RV32I integer operations with a registered one-cycle result and, when compiled in, RV32M multiply operations on an iterative shift-add engine. Sits in the execute stage between operand/decode logic and writeback. Uses valid/ready on both sides so the pipeline can stall on multi-cycle operations. Corrects signed SLT and arithmetic SRA, masks shift amounts, and computes Zero from the new result.

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/alu_mul_iter.sv | 92 +++++++++
 rtl/alu_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, handshake FSM state type and multiply-op decode helpers for alu_pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro used by the importing RTL: ALU_MUL_EN.
package alu_pkg;

   localparam int OP_W = 5;

   localparam logic [OP_W-1:0] OP_ADD    = 5'b00000;
   localparam logic [OP_W-1:0] OP_SUB    = 5'b01000;
   localparam logic [OP_W-1:0] OP_SLL    = 5'b00001;
   localparam logic [OP_W-1:0] OP_SLT    = 5'b00010;
   localparam logic [OP_W-1:0] OP_SLTU   = 5'b00011;
   localparam logic [OP_W-1:0] OP_XOR    = 5'b00100;
   localparam logic [OP_W-1:0] OP_SRL    = 5'b00101;
   localparam logic [OP_W-1:0] OP_SRA    = 5'b01101;
   localparam logic [OP_W-1:0] OP_OR     = 5'b00110;
   localparam logic [OP_W-1:0] OP_AND    = 5'b00111;
   localparam logic [OP_W-1:0] OP_MUL    = 5'b10000;
   localparam logic [OP_W-1:0] OP_MULH   = 5'b10001;
   localparam logic [OP_W-1:0] OP_MULHSU = 5'b10010;
   localparam logic [OP_W-1:0] OP_MULHU  = 5'b10011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,   // output register empty
      ST_BUSY = 2'd1,   // multiply iterating
      ST_HOLD = 2'd2    // result held, out_valid high
   } state_e;

   // Multiply codes occupy 100xx.
   function automatic logic is_mul_op(input logic [OP_W-1:0] op);
      return op[4:2] == 3'b100;
   endfunction

   // Only MUL returns the low half of the product; the MULH* family returns the high half.
   function automatic logic mul_take_high(input logic [OP_W-1:0] op);
      return op[1:0] != 2'b00;
   endfunction

   function automatic logic mul_a_signed(input logic [OP_W-1:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU);
   endfunction

   function automatic logic mul_b_signed(input logic [OP_W-1:0] op);
      return op == OP_MULH;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative shift-add multiplier on operand magnitudes, sign applied at the end.
// Latency: XLEN cycles after start; done pulses combinationally during the final step.
// Backpressure: none; caller must capture product in the cycle done is high. kill aborts.
// Ports: clk, rst_n (async, active-low), kill (sync abort), start, a/b operands,
//        a_signed/b_signed per-operand signedness, done, product (2*XLEN, valid with done).
module alu_mul_iter #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              kill,
   input  logic              start,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic              a_signed,
   input  logic              b_signed,
   output logic              done,
   output logic [2*XLEN-1:0] product
);

   localparam int CNT_W = $clog2(XLEN + 1);

   logic              busy_q,   busy_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [2*XLEN-1:0] acc_q,    acc_d;
   logic [2*XLEN-1:0] mcand_q,  mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic              neg_q,    neg_d;

   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic [2*XLEN-1:0] sum;

   always_comb begin
      a_neg = a_signed & a[XLEN-1];
      b_neg = b_signed & b[XLEN-1];
      // Magnitude of the most negative value still fits as an unsigned XLEN number.
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;

      sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
      done    = busy_q && (cnt_q == CNT_W'(1));
      // Product is exact on the final step; the sign is applied to the completed magnitude.
      product = neg_q ? -sum : sum;

      busy_d   = busy_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;

      if (kill) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (start) begin
         busy_d   = 1'b1;
         cnt_d    = CNT_W'(XLEN);
         acc_d    = '0;
         mcand_d  = {{XLEN{1'b0}}, a_mag};
         mplier_d = b_mag;
         neg_d    = a_neg ^ b_neg;
      end else if (busy_q) begin
         acc_d    = sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         neg_q    <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         neg_q    <= neg_d;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: RV32I execute ALU with valid/ready on both sides; optional RV32M multiply (macro ALU_MUL_EN).
// Latency: base/illegal ops 1 cycle (registered); multiplies XLEN cycles after accept.
// Backpressure: in_ready only when empty or when the held result is taken this cycle; flush kills everything.
// Ports: clk, reset_n (async, active-low), flush; in_valid/in_ready with SrcA, SrcB, ALUControl;
//        out_valid/out_ready with ALUResult, Zero, Illegal (all registered together).
module alu_pipe
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [OP_W-1:0] ALUControl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] ALUResult,
   output logic            Zero,
   output logic            Illegal
);

   localparam int SHAMT_W = $clog2(XLEN);

   state_e          state_q, state_d;
   logic [XLEN-1:0] res_q,   res_d;
   logic            zero_q,  zero_d;
   logic            ill_q,   ill_d;

   logic [SHAMT_W-1:0] shamt;
   logic [XLEN-1:0]    base_res;
   logic               base_ill;
   logic               accept;
   logic               is_mul;

   // Base-op unit: shift amount masked to the low SHAMT_W bits of SrcB.
   always_comb begin
      shamt    = SrcB[SHAMT_W-1:0];
      base_res = '0;
      base_ill = 1'b0;
      case (ALUControl)
         OP_ADD:  base_res = SrcA + SrcB;
         OP_SUB:  base_res = SrcA - SrcB;
         OP_SLL:  base_res = SrcA << shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
         OP_XOR:  base_res = SrcA ^ SrcB;
         OP_SRL:  base_res = SrcA >> shamt;
         OP_SRA:  base_res = $signed(SrcA) >>> shamt;
         OP_OR:   base_res = SrcA | SrcB;
         OP_AND:  base_res = SrcA & SrcB;
         default: base_ill = 1'b1;   // result stays 0, so Zero follows as 1
      endcase
   end

`ifdef ALU_MUL_EN
   logic              mul_start;
   logic              mul_done;
   logic [2*XLEN-1:0] mul_prod;
   logic [XLEN-1:0]   mul_res;
   logic              mul_hi_q, mul_hi_d;

   assign is_mul    = is_mul_op(ALUControl);
   assign mul_start = accept && is_mul;
   assign mul_res   = mul_hi_q ? mul_prod[2*XLEN-1:XLEN] : mul_prod[XLEN-1:0];

   always_comb begin
      mul_hi_d = mul_hi_q;
      if (mul_start) begin
         mul_hi_d = mul_take_high(ALUControl);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_hi_q <= 1'b0;
      end else begin
         mul_hi_q <= mul_hi_d;
      end
   end

   alu_mul_iter #(.XLEN(XLEN)) u_mul (
      .clk      (clk),
      .rst_n    (reset_n),
      .kill     (flush),
      .start    (mul_start),
      .a        (SrcA),
      .b        (SrcB),
      .a_signed (mul_a_signed(ALUControl)),
      .b_signed (mul_b_signed(ALUControl)),
      .done     (mul_done),
      .product  (mul_prod)
   );
`else
   // Multiply codes fall into the base unit's illegal path.
   assign is_mul = 1'b0;
`endif

   // Handshake FSM and output register next-state.
   always_comb begin
      in_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready));
      accept   = in_valid && in_ready;

      state_d = state_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ill_d   = ill_q;

      if (accept) begin
         if (is_mul) begin
            state_d = ST_BUSY;
         end else begin
            state_d = ST_HOLD;
            res_d   = base_res;
            zero_d  = (base_res == '0);
            ill_d   = base_ill;
         end
      end else if ((state_q == ST_HOLD) && out_ready) begin
         state_d = ST_IDLE;
      end
`ifdef ALU_MUL_EN
      else if ((state_q == ST_BUSY) && mul_done) begin
         state_d = ST_HOLD;
         res_d   = mul_res;
         zero_d  = (mul_res == '0);
         ill_d   = 1'b0;
      end
`endif

      // Flush wins over everything; the held/in-flight result is simply dropped.
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   assign out_valid = (state_q == ST_HOLD);
   assign ALUResult = res_q;
   assign Zero      = zero_q;
   assign Illegal   = ill_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed literal checks plus randomized traffic scored against a transaction-level model.
// Latency: n/a.
// Backpressure: randomized out_ready and flush.
module tb_alu_pipe;

   localparam int XLEN = 32;

   localparam logic [4:0] C_ADD = 5'b00000, C_SUB = 5'b01000, C_SLL = 5'b00001, C_SLT = 5'b00010;
   localparam logic [4:0] C_SLTU = 5'b00011, C_XOR = 5'b00100, C_SRL = 5'b00101, C_SRA = 5'b01101;
   localparam logic [4:0] C_OR = 5'b00110, C_AND = 5'b00111, C_MUL = 5'b10000, C_MULH = 5'b10001;
   localparam logic [4:0] C_MULHSU = 5'b10010, C_MULHU = 5'b10011;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] SrcA, SrcB;
   logic [4:0]      ALUControl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] ALUResult;
   logic            Zero;
   logic            Illegal;

   int cmp_cnt = 0;
   int bad_cnt = 0;
   int xfers   = 0;

   always #5 clk = ~clk;

   alu_pipe dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .SrcA       (SrcA),
      .SrcB       (SrcB),
      .ALUControl (ALUControl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .ALUResult  (ALUResult),
      .Zero       (Zero),
      .Illegal    (Illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics straight from the op table, using 64-bit arithmetic for products.
   function automatic void ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      longint          sprod;
      longint unsigned uprod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      r = 32'd0;
      ill = 1'b0;
      lat = 0;
      case (op)
         C_ADD:  r = a + b;
         C_SUB:  r = a - b;
         C_SLL:  r = a << b[4:0];
         C_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
         C_SLTU: r = (ua < ub) ? 32'd1 : 32'd0;
         C_XOR:  r = a ^ b;
         C_SRL:  r = a >> b[4:0];
         C_SRA:  begin sprod = sa >>> b[4:0]; r = sprod[31:0]; end
         C_OR:   r = a | b;
         C_AND:  r = a & b;
`ifdef ALU_MUL_EN
         C_MUL:    begin uprod = ua * ub; r = uprod[31:0];  lat = XLEN; end
         C_MULH:   begin sprod = sa * sb; r = sprod[63:32]; lat = XLEN; end
         C_MULHSU: begin sprod = sa * longint'(ub); r = sprod[63:32]; lat = XLEN; end
         C_MULHU:  begin uprod = ua * ub; r = uprod[63:32]; lat = XLEN; end
`endif
         default: ill = 1'b1;
      endcase
   endfunction

   // Transaction-level model: whether a result is visible, what it is, and cycles still to wait.
   logic        m_vld;
   int          m_wait;
   logic [31:0] m_res;
   logic        m_ill;
   logic [31:0] t_res;
   logic        t_ill;
   int          t_lat;
   logic        t_take;

   function automatic logic model_rdy();
      return !flush && (m_wait == 0) && (!m_vld || out_ready);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_vld = 1'b0; m_wait = 0; m_res = 32'd0; m_ill = 1'b0;
      end else begin
         t_take = in_valid && model_rdy();
         if (flush) begin
            m_vld = 1'b0; m_wait = 0;
         end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) m_vld = 1'b1;
         end else if (t_take) begin
            ref_op(ALUControl, SrcA, SrcB, t_res, t_ill, t_lat);
            m_res = t_res;
            m_ill = t_ill;
            if (t_lat == 0) begin
               m_vld = 1'b1;
            end else begin
               m_vld = 1'b0; m_wait = t_lat;
            end
         end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
         end
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         chk("sb_in_ready", in_ready, model_rdy());
         chk("sb_out_valid", out_valid, m_vld);
         if (m_vld) begin
            chk("sb_result", ALUResult, m_res);
            chk("sb_zero", Zero, (m_res == 32'd0));
            chk("sb_illegal", Illegal, m_ill);
         end
      end
   end

   always @(negedge clk) begin
      if (reset_n === 1'b1 && out_valid && out_ready) xfers++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic eill, input int elat);
      int n;
      int lat;
      bit got;
      bit rdy_seen;
      @(posedge clk); #1;
      in_valid = 1'b1; ALUControl = op; SrcA = a; SrcB = b; out_ready = 1'b1; flush = 1'b0;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0; got = 1'b0; rdy_seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (out_valid) begin got = 1'b1; break; end
         if (in_ready) rdy_seen = 1'b1;
         lat++;
      end
      chk({name, "_valid"}, got, 1'b1);
      chk({name, "_res"}, ALUResult, er);
      chk({name, "_zero"}, Zero, (er == 32'd0));
      chk({name, "_ill"}, Illegal, eill);
      chk({name, "_lat"}, lat, elat);
      chk({name, "_rdy_while_busy"}, rdy_seen, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   logic [4:0] ops [14];
   int         x0;
   bit         seen;

   initial begin
      ops = '{C_ADD, C_SUB, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_SRA, C_OR, C_AND,
              C_MUL, C_MULH, C_MULHSU, C_MULHU};
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; SrcA = '0; SrcB = '0;
      ALUControl = C_ADD; out_ready = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_zero", Zero, 1'b0);
      chk("rst_illegal", Illegal, 1'b0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);

      run_op("slt",  C_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
      run_op("sltu", C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
      run_op("sra",  C_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 0);
      run_op("srl",  C_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 0);
      run_op("sll_mask", C_SLL, 32'd1, 32'h21, 32'd2, 1'b0, 0);
      run_op("sub_zero", C_SUB, 32'd5, 32'd5, 32'd0, 1'b0, 0);
      run_op("add_wrap", C_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 0);
      run_op("illegal", 5'b11111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 0);
`ifdef ALU_MUL_EN
      run_op("mulh",  C_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, XLEN);
      run_op("mul",   C_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, XLEN);
      run_op("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, XLEN);
      run_op("mulhsu", C_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, XLEN);
`else
      run_op("mul_disabled", C_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 0);
      run_op("mulhu_disabled", C_MULHU, 32'd3, 32'd3, 32'd0, 1'b1, 0);
`endif

      // Back-to-back ADDs: one result per cycle.
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i == 0) x0 = xfers;
         in_valid = 1'b1; ALUControl = C_ADD; SrcA = 32'(i + 10); SrcB = 32'd1;
         @(negedge clk);
         chk("b2b_in_ready", in_ready, 1'b1);
         if (i > 0) begin
            chk("b2b_out_valid", out_valid, 1'b1);
            chk("b2b_res", ALUResult, 32'(i + 10));
         end
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_last_res", ALUResult, 32'd14);
      #1 chk("b2b_xfers", xfers - x0, 4);

      // Stall with out_ready low: result held, nothing else accepted, one transfer.
      @(posedge clk); #1;
      in_valid = 1'b1; ALUControl = C_XOR; SrcA = 32'hF0F0_F0F0; SrcB = 32'h0F0F_0F0F; out_ready = 1'b0;
      @(posedge clk); #1;
      ALUControl = C_ADD; SrcA = 32'd1; SrcB = 32'd1;
      x0 = xfers;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_res", ALUResult, 32'hFFFF_FFFF);
         chk("hold_in_ready", in_ready, 1'b0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_rdy", in_ready, 1'b1);
      @(posedge clk); #1 in_valid = 1'b0;
      chk("hold_single_xfer", xfers - x0, 1);
      @(negedge clk);
      chk("hold_next_res", ALUResult, 32'd2);

      // Flush ten cycles into a multiply (held illegal result when multiply is not built).
      @(posedge clk); #1;
      in_valid = 1'b1; ALUControl = C_MULHSU; SrcA = 32'hFFFF_FFFF; SrcB = 32'd5; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1; in_valid = 1'b1; ALUControl = C_ADD; SrcA = 32'd7; SrcB = 32'd7;
      @(negedge clk);
      chk("flush_in_ready", in_ready, 1'b0);
      @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      chk("flush_no_result", seen, 1'b0);
      run_op("after_flush", C_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0);

      // Reset in the middle of a multiply.
      @(posedge clk); #1;
      in_valid = 1'b1; ALUControl = C_MUL; SrcA = 32'd12345; SrcB = 32'd678; out_ready = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_res", ALUResult, 32'd0);
      chk("midrst_ill", Illegal, 1'b0);
      @(posedge clk); #1 reset_n = 1'b1; out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (out_valid) seen = 1'b1; end
      chk("midrst_no_result", seen, 1'b0);
      run_op("after_reset", C_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 0);

      // Randomized traffic, scored every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         in_valid   = ($urandom_range(0, 9) < 7);
         ALUControl = ($urandom_range(0, 15) == 0) ? 5'($urandom) : ops[$urandom_range(0, 13)];
         SrcA       = pick();
         SrcB       = pick();
         out_ready  = ($urandom_range(0, 9) < 7);
         flush      = ($urandom_range(0, 49) == 0);
      end
      @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end

endmodule
